// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap stopwatch with prescaled elapsed counter and a small lap-record memory.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W = 16,
  parameter int LAP_DEPTH = 4,
  localparam int IDX_W = LAP_DEPTH > 1 ? $clog2(LAP_DEPTH) : 1,
  localparam int LC_W = $clog2(LAP_DEPTH + 1),
  localparam int DIV_W = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_ss,
  input  logic             btn_lap,
  input  logic [IDX_W-1:0] lap_rd_idx,
  output logic             count_enable,
  output logic             led_en,
  output logic [CNT_W-1:0] elapsed,
  output logic [CNT_W-1:0] display,
  output logic [LC_W-1:0]  lap_count,
  output logic             lap_full,
  output logic [CNT_W-1:0] lap_rd_data
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t state, nxt;
  logic ss_prev, lap_prev, ss_p, lap_p, clear, tick, lap_go, lap_wr;
  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] el_nxt;
  logic [CNT_W-1:0] mem [LAP_DEPTH];
  assign ss_p = btn_ss & ~ss_prev;
  assign lap_p = btn_lap & ~lap_prev;
  assign led_en = count_enable;
  assign lap_full = lap_count == LC_W'(LAP_DEPTH);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ss_p ? RUN : IDLE;
      RUN:     nxt = ss_p ? PAUSE : lap_p ? LAP : RUN;
      LAP:     nxt = ss_p ? PAUSE : lap_p ? RUN : LAP;
      default: nxt = ss_p ? RUN : lap_p ? IDLE : PAUSE;
    endcase
  end
  assign clear = state == PAUSE && nxt == IDLE;
  assign tick = count_enable && div == DIV_W'(TICK_DIV - 1);
  assign div_nxt = clear || tick ? '0 : count_enable ? div + DIV_W'(1) : div;
  assign el_nxt = clear ? '0 : tick ? elapsed + CNT_W'(1) : elapsed;
  // Only RUN can enter LAP, so lap_go marks the capture edge.
  assign lap_go = state == RUN && nxt == LAP;
  assign lap_wr = !reset && lap_go && !lap_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ss_prev <= 1'b1;
      lap_prev <= 1'b1;
      count_enable <= 1'b0;
      div <= '0;
      elapsed <= '0;
      display <= '0;
      lap_count <= '0;
      lap_rd_data <= '0;
    end else begin
      state <= nxt;
      ss_prev <= btn_ss;
      lap_prev <= btn_lap;
      count_enable <= nxt == RUN || nxt == LAP;
      div <= div_nxt;
      elapsed <= el_nxt;
      display <= nxt == LAP ? (lap_go ? elapsed : display) : el_nxt;
      lap_count <= clear ? '0 : lap_wr ? lap_count + LC_W'(1) : lap_count;
      lap_rd_data <= int'(lap_rd_idx) < int'(lap_count) ? mem[lap_rd_idx] : '0;
    end
  end
  always_ff @(posedge clk)
    if (lap_wr) mem[lap_count[IDX_W-1:0]] <= elapsed;
endmodule
